pll_reset_seq: RTL

Reset sequencer and timebase that sits directly downstream of the Tang Nano 9K rPLL. It runs in the PLL output clock domain and synchronises the raw PLL lock signal. It holds the design's system reset asserted until lock has been stable for a programmable number of cycles, and drops it again if lock is lost. Once running, it provides a periodic one-cycle tick and a count of lock-loss events.

---
 rtl/pll_reset_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
// Reset sequencer and timebase for the logic downstream of the rPLL. It runs
// entirely in the PLL output clock domain. The raw LOCK signal passes through
// a two-flop synchroniser. The system reset stays asserted until lock has been
// stable for LOCK_CYCLES consecutive cycles, and is asserted again when lock
// drops. While running, the block emits a one-cycle tick every TICK_DIV cycles.
//
// Optional feature macro: PLL_LOSS_COUNT_EN
//   defined   -> saturating 8-bit lock-loss counter drives loss_cnt
//   undefined -> no counter is built, loss_cnt is tied to zero
//
// Ports:
//   clk        in   PLL output clock, the only clock
//   rst_n      in   synchronous active-low reset
//   lock_in    in   raw rPLL LOCK, asynchronous to clk
//   sys_rst_n  out  registered system reset, 0 = downstream held in reset
//   locked     out  lock_in after the two-flop synchroniser
//   tick       out  one-cycle pulse every TICK_DIV cycles while running
//   loss_cnt   out  saturating count of lock losses while running
// -----------------------------------------------------------------------------
module pll_reset_seq #(
   parameter int LOCK_CYCLES = 1024,
   parameter int TICK_DIV    = 54000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lock_in,
   output logic       sys_rst_n,
   output logic       locked,
   output logic       tick,
   output logic [7:0] loss_cnt
);

   localparam int CNT_W  = $clog2(LOCK_CYCLES + 1);
   localparam int TICK_W = $clog2(TICK_DIV);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_STABLE    = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;

   logic              sync1_r;
   logic              lock_sync_r;
   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic [TICK_W-1:0] tick_cnt_r;
   logic              tick_run_s;

   // Next-state and stability-count logic
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_WAIT_LOCK: begin
            cnt_nxt_s = {CNT_W{1'b0}};
            if (lock_sync_r) begin
               state_nxt_s = ST_STABLE;
            end else begin
               state_nxt_s = ST_WAIT_LOCK;
            end
         end
         ST_STABLE: begin
            // A lock drop is checked first so it wins over a count completing
            // on the same edge.
            if (!lock_sync_r) begin
               state_nxt_s = ST_WAIT_LOCK;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               state_nxt_s = ST_STABLE;
               cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
            end
         end
         ST_RUN: begin
            cnt_nxt_s = {CNT_W{1'b0}};
            if (!lock_sync_r) begin
               state_nxt_s = ST_WAIT_LOCK;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // The tick counter only advances while the sequencer stays in RUN, so the
   // edge that leaves RUN already produces tick=0 and the edge that enters RUN
   // leaves the counter at zero.
   assign tick_run_s = (state_r == ST_RUN) && lock_sync_r;

   // Lock synchroniser, FSM state, stability counter and system reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_r     <= 1'b0;
         lock_sync_r <= 1'b0;
         state_r     <= ST_WAIT_LOCK;
         cnt_r       <= {CNT_W{1'b0}};
         sys_rst_n   <= 1'b0;
      end else begin
         sync1_r     <= lock_in;
         lock_sync_r <= sync1_r;
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         sys_rst_n   <= (state_nxt_s == ST_RUN);
      end
   end

   // Periodic tick generator
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_r <= {TICK_W{1'b0}};
         tick       <= 1'b0;
      end else if (!tick_run_s) begin
         tick_cnt_r <= {TICK_W{1'b0}};
         tick       <= 1'b0;
      end else if (tick_cnt_r == TICK_LAST) begin
         tick_cnt_r <= {TICK_W{1'b0}};
         tick       <= 1'b1;
      end else begin
         tick_cnt_r <= tick_cnt_r + TICK_W'(1'b1);
         tick       <= 1'b0;
      end
   end

   assign locked = lock_sync_r;

`ifdef PLL_LOSS_COUNT_EN
   logic       loss_event_s;
   logic [7:0] loss_cnt_r;

   // Only a RUN -> WAIT_LOCK transition is a loss; drops during STABLE are not.
   assign loss_event_s = (state_r == ST_RUN) && !lock_sync_r;

   // Saturating lock-loss counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         loss_cnt_r <= 8'd0;
      end else if (loss_event_s && (loss_cnt_r != 8'd255)) begin
         loss_cnt_r <= loss_cnt_r + 8'd1;
      end else begin
         loss_cnt_r <= loss_cnt_r;
      end
   end

   assign loss_cnt = loss_cnt_r;
`else
   assign loss_cnt = 8'd0;
`endif

endmodule
